// File: rtl/mem_stall_controller.sv
// Pipeline sequencing controller for the five-stage MIPS datapath: memory-wait
// stall with timeout, load-use interlock and taken-branch flush.
module mem_stall_controller #(
  parameter int unsigned TIMEOUT     = 255,
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   EXMEM_MemRead,
  input  logic                   EXMEM_MemWrite,
  input  logic                   MemAck,
  output logic                   MemReq,
  input  logic                   IDEX_MemRead,
  input  logic [4:0]             IDEX_Rt,
  input  logic [4:0]             IFID_Rs,
  input  logic [4:0]             IFID_Rt,
  input  logic                   IFID_UsesRt,
  input  logic                   BranchTaken,
  output logic                   PCWriteEn,
  output logic                   IFIDWriteEn,
  output logic                   IFIDFlush,
  output logic                   IDEXWriteEn,
  output logic                   IDEXFlush,
  output logic                   EXMEMWriteEn,
  output logic                   MEMWBBubble,
  output logic                   MemError,
  output logic [STALL_CNT_W-1:0] StallCycles,
  output logic [1:0]             DebugState
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    ABORT = 2'd2
  } state_t;

  localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);
  localparam logic [STALL_CNT_W-1:0] STALL_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

  state_t      state, state_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic        access;
  logic        load_use;
  logic        mem_stall;
  logic        mem_req_c;
  logic        abort_c;
  logic        set_error;

  assign access   = EXMEM_MemRead | EXMEM_MemWrite;
  assign load_use = IDEX_MemRead && (IDEX_Rt != 5'd0) &&
                    ((IDEX_Rt == IFID_Rs) || (IFID_UsesRt && (IDEX_Rt == IFID_Rt)));
  assign DebugState = state;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state       <= IDLE;
      cnt         <= 16'd0;
      MemError    <= 1'b0;
      StallCycles <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (set_error) MemError <= 1'b1;
      if (!PCWriteEn && (StallCycles != '1)) StallCycles <= StallCycles + STALL_ONE;
    end
  end

  // Memory handshake FSM; cnt counts WAIT cycles already spent without an ack.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    mem_req_c = 1'b0;
    mem_stall = 1'b0;
    abort_c   = 1'b0;
    set_error = 1'b0;
    case (state)
      IDLE: begin
        mem_req_c = access;
        if (access && !MemAck) begin
          mem_stall = 1'b1;
          state_nxt = WAIT;
          cnt_nxt   = 16'd1;
        end
      end
      WAIT: begin
        mem_req_c = 1'b1;
        if (MemAck) begin
          state_nxt = IDLE;
          cnt_nxt   = 16'd0;
        end else if (cnt == TIMEOUT_CNT) begin
          mem_stall = 1'b1;
          state_nxt = ABORT;
          set_error = 1'b1;
        end else begin
          mem_stall = 1'b1;
          cnt_nxt   = cnt + 16'd1;
        end
      end
      ABORT: begin
        abort_c   = 1'b1;
        state_nxt = IDLE;
        cnt_nxt   = 16'd0;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 16'd0;
      end
    endcase
  end

  // Pipeline controls; priority is memory stall, then load-use, then branch.
  // While Reset is low everything is frozen and MEM/WB is bubbled.
  always_comb begin
    MemReq       = 1'b0;
    PCWriteEn    = 1'b0;
    IFIDWriteEn  = 1'b0;
    IFIDFlush    = 1'b0;
    IDEXWriteEn  = 1'b0;
    IDEXFlush    = 1'b0;
    EXMEMWriteEn = 1'b0;
    MEMWBBubble  = 1'b1;
    if (Reset) begin
      MemReq = mem_req_c;
      if (!mem_stall) begin
        PCWriteEn    = 1'b1;
        IFIDWriteEn  = 1'b1;
        IDEXWriteEn  = 1'b1;
        EXMEMWriteEn = 1'b1;
        MEMWBBubble  = abort_c;
        if (load_use) begin
          PCWriteEn   = 1'b0;
          IFIDWriteEn = 1'b0;
          IDEXFlush   = 1'b1;
        end else if (BranchTaken) begin
          IFIDFlush = 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_stall_controller.sv
// Bench for mem_stall_controller: directed scenarios followed by random traffic,
// all checked cycle by cycle against a request-age reference model.
module tb_mem_stall_controller;

  localparam int TO = 4;
  localparam int SW = 16;

  logic          Clk = 1'b0;
  logic          Reset;
  logic          EXMEM_MemRead, EXMEM_MemWrite, MemAck, MemReq;
  logic          IDEX_MemRead;
  logic [4:0]    IDEX_Rt, IFID_Rs, IFID_Rt;
  logic          IFID_UsesRt, BranchTaken;
  logic          PCWriteEn, IFIDWriteEn, IFIDFlush, IDEXWriteEn, IDEXFlush;
  logic          EXMEMWriteEn, MEMWBBubble, MemError;
  logic [SW-1:0] StallCycles;
  logic [1:0]    DebugState;

  always #5 Clk = ~Clk;

  mem_stall_controller #(.TIMEOUT(TO), .STALL_CNT_W(SW)) dut (
    .Clk(Clk), .Reset(Reset),
    .EXMEM_MemRead(EXMEM_MemRead), .EXMEM_MemWrite(EXMEM_MemWrite),
    .MemAck(MemAck), .MemReq(MemReq),
    .IDEX_MemRead(IDEX_MemRead), .IDEX_Rt(IDEX_Rt),
    .IFID_Rs(IFID_Rs), .IFID_Rt(IFID_Rt), .IFID_UsesRt(IFID_UsesRt),
    .BranchTaken(BranchTaken),
    .PCWriteEn(PCWriteEn), .IFIDWriteEn(IFIDWriteEn), .IFIDFlush(IFIDFlush),
    .IDEXWriteEn(IDEXWriteEn), .IDEXFlush(IDEXFlush),
    .EXMEMWriteEn(EXMEMWriteEn), .MEMWBBubble(MEMWBBubble),
    .MemError(MemError), .StallCycles(StallCycles), .DebugState(DebugState)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: age = unacknowledged cycles of the outstanding request.
  int unsigned m_age;
  bit          m_abort, m_err;
  int unsigned m_stalls;
  bit          e_req, e_pc;
  logic [8:0]  exp_vec;

  task automatic model_reset();
    m_age = 0; m_abort = 0; m_err = 0; m_stalls = 0;
  endtask

  task automatic model_eval();
    bit acc, lu, ms, ab;
    acc = EXMEM_MemRead | EXMEM_MemWrite;
    lu  = IDEX_MemRead && IDEX_Rt != 0 &&
          (IDEX_Rt == IFID_Rs || (IFID_UsesRt && IDEX_Rt == IFID_Rt));
    ab = 0; ms = 0; e_req = 0;
    if (m_abort) ab = 1;
    else if (m_age > 0 || acc) begin e_req = 1; ms = !MemAck; end
    e_pc = !ms && !lu;
    exp_vec = {e_req, e_pc, e_pc, !ms && !lu && BranchTaken, !ms, !ms && lu,
               !ms, ms || ab, m_err};
  endtask

  task automatic model_commit();
    if (m_abort) begin
      m_abort = 0; m_age = 0;
    end else if (e_req) begin
      if (MemAck) m_age = 0;
      else if (m_age + 1 == TO + 1) begin m_abort = 1; m_err = 1; m_age = 0; end
      else m_age = m_age + 1;
    end
    if (!e_pc && m_stalls < (2**SW - 1)) m_stalls = m_stalls + 1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ctl_vec();
    return {23'd0, MemReq, PCWriteEn, IFIDWriteEn, IFIDFlush, IDEXWriteEn,
            IDEXFlush, EXMEMWriteEn, MEMWBBubble, MemError};
  endfunction

  // Inputs are set just after a rising edge; outputs are checked on the falling edge.
  task automatic cyc(input string tag);
    @(negedge Clk);
    model_eval();
    check({tag, "_ctl"}, ctl_vec(), {23'd0, exp_vec});
    check({tag, "_stalls"}, {16'd0, StallCycles}, m_stalls);
    @(posedge Clk);
    model_commit();
    #1;
  endtask

  task automatic set_mem(input logic rd, input logic wr, input logic ack);
    EXMEM_MemRead = rd; EXMEM_MemWrite = wr; MemAck = ack;
  endtask

  task automatic set_id(input logic mr, input logic [4:0] xrt, input logic [4:0] rs,
                        input logic [4:0] rt, input logic uses, input logic br);
    IDEX_MemRead = mr; IDEX_Rt = xrt; IFID_Rs = rs; IFID_Rt = rt;
    IFID_UsesRt = uses; BranchTaken = br;
  endtask

  initial begin
    Reset = 1'b0;
    set_mem(1, 0, 0);
    set_id(0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge Clk);
    #1;
    check("reset_forced", ctl_vec(), {23'd0, 9'b0_0000_0010});
    check("reset_stalls", {16'd0, StallCycles}, 0);
    check("reset_state", {30'd0, DebugState}, 0);
    Reset = 1'b1;

    // Zero-wait accesses never stall.
    set_mem(1, 0, 1);
    repeat (4) cyc("zero_wait");
    check("zero_wait_total", {16'd0, StallCycles}, 0);

    // Ack three cycles after the request.
    set_mem(1, 0, 0);
    repeat (3) cyc("wait3");
    MemAck = 1;
    cyc("wait3_ack");
    set_mem(0, 0, 0);
    cyc("wait3_after");
    check("wait3_total", {16'd0, StallCycles}, 3);

    // No ack: TIMEOUT+1 stall cycles, one abort cycle, sticky error.
    set_mem(0, 1, 0);
    repeat (TO + 1) cyc("timeout");
    cyc("abort");
    set_mem(0, 0, 0);
    cyc("post_abort");
    check("error_sticky", {31'd0, MemError}, 1);
    check("timeout_total", {16'd0, StallCycles}, 3 + TO + 1);

    // Ack arriving together with the timeout count wins.
    set_mem(1, 0, 0);
    repeat (TO) cyc("late");
    MemAck = 1;
    cyc("late_ack");
    set_mem(0, 0, 0);

    // Load-use beats branch, then the branch flushes once the load moves on.
    set_id(1, 5, 5, 0, 0, 1);
    cyc("lu_branch");
    set_id(0, 5, 5, 0, 0, 1);
    cyc("branch_after_lu");
    set_id(1, 0, 0, 0, 1, 0);
    cyc("lu_r0");
    set_id(1, 7, 1, 7, 0, 0);
    cyc("lu_rt_unused");
    set_id(1, 7, 1, 7, 1, 0);
    cyc("lu_rt_used");
    set_id(0, 0, 0, 0, 0, 0);

    // Ack with no access is ignored.
    set_mem(0, 0, 1);
    cyc("ack_idle");

    // Reset during the second WAIT cycle.
    set_mem(1, 0, 0);
    cyc("pre_reset_idle");
    cyc("pre_reset_wait1");
    #2 Reset = 1'b0;
    #1;
    check("mid_reset_req", {31'd0, MemReq}, 0);
    check("mid_reset_stalls", {16'd0, StallCycles}, 0);
    check("mid_reset_err", {31'd0, MemError}, 0);
    check("mid_reset_state", {30'd0, DebugState}, 0);
    model_reset();
    @(posedge Clk);
    #1 Reset = 1'b1;
    cyc("post_reset_req");
    MemAck = 1;
    cyc("post_reset_ack");

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      set_mem($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
              $urandom_range(0, 9) < 3);
      set_id($urandom_range(0, 1), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), $urandom_range(0, 1), $urandom_range(0, 3) == 0);
      cyc("random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
